sos_sequencer: RTL and testbench
================================

// Module: sos_sequencer
// PURPOSE
//  Upstream controller for the S/O letter generators. On a Trig rising edge it plays REPEAT
//  words of "S O S". For each letter it holds that generator's Start_Sig high until the
//  generator's Done_Sig. It inserts timed letter and word gaps between letters and words.
//  Pulses Done_Sig once after the last S of the last word.
// PARAMETERS
//  T1MS           16'd49_999  clocks per 1 ms tick minus 1 (50 MHz)
//  LETTER_GAP_MS  10'd150     silent gap between letters, ms (must be >=1)
//  WORD_GAP_MS    10'd350     silent gap between words, ms (must be >=1)
//  REPEAT         4'd3        SOS words per trigger; 0 treated as 1
// PORTS
//  CLK          in   1  system clock
//  RSTn         in   1  asynchronous active-low reset
//  Trig         in   1  request level, synchronous to CLK; rising edge starts a run
//  S_Done_Sig   in   1  1-cycle done pulse from S generator
//  O_Done_Sig   in   1  1-cycle done pulse from O generator
//  S_Start_Sig  out  1  level run-enable to S generator
//  O_Start_Sig  out  1  level run-enable to O generator
//  Busy         out  1  high while a run is in progress
//  Done_Sig     out  1  1-cycle pulse at end of run
// BEHAVIOUR
//  One clock, CLK. Reset is asynchronous and active-low on RSTn.
//  Reset: state=IDLE, all outputs 0, counters 0, Trig_d=1. Trig_d=1 means a Trig already
//   high at reset release is not an edge.
//  Edge: rise = Trig & ~Trig_d, with Trig_d registered every cycle. A rise outside IDLE is
//   ignored and not queued.
//  States: IDLE, S1, G1, O, G2, S2, WG, FIN. All outputs are registered.
//  IDLE: on rise -> S1. Load word counter = (REPEAT==0)?1:REPEAT. Busy=1, S_Start_Sig=1 from
//   the next cycle (1-cycle latency).
//  S1/S2: S_Start_Sig=1 held. When S_Done_Sig is sampled 1, drop S_Start_Sig at that edge:
//   S1->G1; S2->FIN if word counter==1, else decrement and go to WG.
//  O: O_Start_Sig=1 held. When O_Done_Sig is sampled 1, drop O_Start_Sig and go to G2.
//  Done pulses from the idle generator, or in any non-matching state, are ignored.
//  Start_Sig leaves IDLE as 0 and only rises on the edge that enters S1/S2/O, so S and O are
//   never high together. A Start_Sig is low for >=1 cycle between consecutive letters.
//  Gap timer: Count1 runs 0..T1MS while in G1/G2/WG, and is 0 elsewhere. Each wrap is a ms
//   tick that increments Count_MS.
//  Gap exit: leave on the tick where Count_MS == gap-1. Dwell is exactly
//   gap*(T1MS+1) cycles, after which the counters clear.
//  Gap transitions: G1->O and G2->S2 use LETTER_GAP_MS. WG->S1 uses WORD_GAP_MS.
//  FIN: Done_Sig=1 and Busy=0 for one cycle, then IDLE. There is no trailing word gap.
//  Done_Sig is never asserted during reset or IDLE.
//  Widths: Count1 16b, Count_MS 10b, word counter 4b. No wrap is possible within the
//   parameter ranges.
//  Reset mid-run: returns to the reset state immediately. The outputs drop asynchronously.
//   A new run needs a fresh Trig rise.
//  Simultaneous Done and reset: reset wins.
// TESTING  (bench params T1MS=9, LETTER_GAP_MS=2, WORD_GAP_MS=3, REPEAT=2; model gens)
//  1 Trig 0->1 at cycle 10 -> S_Start_Sig=1 from cycle 11, Busy=1. Model S_Done at cycle 30
//    -> S_Start_Sig=0 at 31 and exactly 20 idle cycles, then O_Start_Sig=1 at 51.
//  2 Full run, REPEAT=2 -> Start sequence S,O,S,S,O,S. Letter gaps are 20 cycles and the
//    word gap is 30 cycles. A single Done_Sig follows the last S_Done, and Busy falls with it.
//  3 Trig pulses during the run, plus spurious O_Done in S1 -> no effect on the sequence
//    or timing.
//  4 Trig held high across reset release -> stays IDLE. Trig 0 then 1 -> run starts.
//  5 RSTn low during O -> O_Start_Sig=0, Busy=0 immediately. After release, IDLE with no
//    Done_Sig.
//  6 REPEAT=0 -> exactly one S-O-S word, then Done_Sig. REPEAT=1 gives identical output.

Source files
------------

// File: rtl/sos_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sos_sequencer
//  Description : Upstream controller for the S/O letter generators. A rising
//                edge on Trig plays REPEAT words of "S O S". Each generator's
//                Start_Sig is held high until that generator's Done_Sig, with
//                timed letter and word gaps between them. Done_Sig pulses once
//                after the last S of the last word.
//  Revision    : 1.0  initial release
// ============================================================================
module sos_sequencer #(
    parameter logic [15:0] T1MS          = 16'd49_999,
    parameter logic [9:0]  LETTER_GAP_MS = 10'd150,
    parameter logic [9:0]  WORD_GAP_MS   = 10'd350,
    parameter logic [3:0]  REPEAT        = 4'd3
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Trig,
    input  logic S_Done_Sig,
    input  logic O_Done_Sig,
    output logic S_Start_Sig,
    output logic O_Start_Sig,
    output logic Busy,
    output logic Done_Sig
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_G1   = 3'd2,
        ST_O    = 3'd3,
        ST_G2   = 3'd4,
        ST_S2   = 3'd5,
        ST_WG   = 3'd6,
        ST_FIN  = 3'd7
    } state_t;

    // A REPEAT of zero still plays one word.
    localparam logic [3:0] c_word_load   = (REPEAT == 4'd0) ? 4'd1 : REPEAT;
    // The gap ends on the ms tick where the ms count reaches gap-1.
    localparam logic [9:0] c_letter_last = LETTER_GAP_MS - 10'd1;
    localparam logic [9:0] c_word_last   = WORD_GAP_MS - 10'd1;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_trig_d;
    logic [15:0]  r_count1;
    logic [15:0]  w_count1_nxt;
    logic [9:0]   r_count_ms;
    logic [9:0]   w_count_ms_nxt;
    logic [3:0]   r_word_cnt;
    logic [3:0]   w_word_cnt_nxt;
    logic         r_s_start;
    logic         w_s_start_nxt;
    logic         r_o_start;
    logic         w_o_start_nxt;
    logic         r_busy;
    logic         w_busy_nxt;
    logic         r_done;
    logic         w_done_nxt;

    logic         w_rise;
    logic         w_in_gap;
    logic         w_tick;
    logic [9:0]   w_gap_last;
    logic         w_gap_end;

    // Trigger edge detect and gap-timer decode.
    always_comb begin
        w_rise     = Trig & ~r_trig_d;
        w_in_gap   = (r_state == ST_G1) || (r_state == ST_G2) || (r_state == ST_WG);
        w_tick     = w_in_gap && (r_count1 == T1MS);
        w_gap_last = (r_state == ST_WG) ? c_word_last : c_letter_last;
        w_gap_end  = w_tick && (r_count_ms == w_gap_last);
    end

    // Gap timer: the 1 ms prescaler wraps into the ms counter; both are
    // zero outside the gap states so each gap starts from a clean count.
    always_comb begin
        w_count1_nxt   = 16'd0;
        w_count_ms_nxt = 10'd0;
        if (w_in_gap) begin
            if (w_tick) begin
                w_count1_nxt   = 16'd0;
                w_count_ms_nxt = w_gap_end ? 10'd0 : (r_count_ms + 10'd1);
            end else begin
                w_count1_nxt   = r_count1 + 16'd1;
                w_count_ms_nxt = r_count_ms;
            end
        end
    end

    // Next-state and next-output logic; every output is registered so a
    // Start_Sig only rises on the edge that enters its letter state.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_s_start_nxt  = r_s_start;
        w_o_start_nxt  = r_o_start;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_start_nxt = 1'b0;
                w_o_start_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
                if (w_rise) begin
                    w_state_nxt    = ST_S1;
                    w_word_cnt_nxt = c_word_load;
                    w_s_start_nxt  = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end
            ST_S1: begin
                if (S_Done_Sig) begin
                    w_state_nxt   = ST_G1;
                    w_s_start_nxt = 1'b0;
                end
            end
            ST_G1: begin
                if (w_gap_end) begin
                    w_state_nxt   = ST_O;
                    w_o_start_nxt = 1'b1;
                end
            end
            ST_O: begin
                if (O_Done_Sig) begin
                    w_state_nxt   = ST_G2;
                    w_o_start_nxt = 1'b0;
                end
            end
            ST_G2: begin
                if (w_gap_end) begin
                    w_state_nxt   = ST_S2;
                    w_s_start_nxt = 1'b1;
                end
            end
            ST_S2: begin
                if (S_Done_Sig) begin
                    w_s_start_nxt = 1'b0;
                    if (r_word_cnt == 4'd1) begin
                        // Last word: no trailing word gap, finish directly.
                        w_state_nxt = ST_FIN;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt    = ST_WG;
                        w_word_cnt_nxt = r_word_cnt - 4'd1;
                    end
                end
            end
            ST_WG: begin
                if (w_gap_end) begin
                    w_state_nxt   = ST_S1;
                    w_s_start_nxt = 1'b1;
                end
            end
            ST_FIN: begin
                w_state_nxt   = ST_IDLE;
                w_s_start_nxt = 1'b0;
                w_o_start_nxt = 1'b0;
                w_busy_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_word_cnt_nxt = 4'd0;
                w_s_start_nxt  = 1'b0;
                w_o_start_nxt  = 1'b0;
                w_busy_nxt     = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; Trig_d resets high so a Trig
    // already high at reset release is not taken as an edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_trig_d   <= 1'b1;
            r_count1   <= 16'd0;
            r_count_ms <= 10'd0;
            r_word_cnt <= 4'd0;
            r_s_start  <= 1'b0;
            r_o_start  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_trig_d   <= Trig;
            r_count1   <= w_count1_nxt;
            r_count_ms <= w_count_ms_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_s_start  <= w_s_start_nxt;
            r_o_start  <= w_o_start_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign S_Start_Sig = r_s_start;
    assign O_Start_Sig = r_o_start;
    assign Busy        = r_busy;
    assign Done_Sig    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sos_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sos_sequencer
//  Description : Self-checking bench for sos_sequencer with small timing
//                parameters (1 ms = 10 clocks, letter gap 20, word gap 30).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sos_sequencer;

    localparam logic [15:0] P_T1MS = 16'd9;
    localparam logic [9:0]  P_LG   = 10'd2;
    localparam logic [9:0]  P_WG   = 10'd3;

    logic CLK = 1'b0;
    logic RSTn, Trig, S_Done_Sig, O_Done_Sig;
    logic S_Start_Sig, O_Start_Sig, Busy, Done_Sig;

    // Auxiliary REPEAT=0 and REPEAT=1 instances with auto-responding generators.
    logic Trig_a;
    logic a0_sd, a0_od, a0_s, a0_o, a0_b, a0_d;
    logic a1_sd, a1_od, a1_s, a1_o, a1_b, a1_d;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sos_sequencer #(.T1MS(P_T1MS), .LETTER_GAP_MS(P_LG), .WORD_GAP_MS(P_WG), .REPEAT(4'd2)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .Trig(Trig), .S_Done_Sig(S_Done_Sig), .O_Done_Sig(O_Done_Sig),
        .S_Start_Sig(S_Start_Sig), .O_Start_Sig(O_Start_Sig), .Busy(Busy), .Done_Sig(Done_Sig));

    sos_sequencer #(.T1MS(P_T1MS), .LETTER_GAP_MS(P_LG), .WORD_GAP_MS(P_WG), .REPEAT(4'd0)) u_dut_r0 (
        .CLK(CLK), .RSTn(RSTn), .Trig(Trig_a), .S_Done_Sig(a0_sd), .O_Done_Sig(a0_od),
        .S_Start_Sig(a0_s), .O_Start_Sig(a0_o), .Busy(a0_b), .Done_Sig(a0_d));

    sos_sequencer #(.T1MS(P_T1MS), .LETTER_GAP_MS(P_LG), .WORD_GAP_MS(P_WG), .REPEAT(4'd1)) u_dut_r1 (
        .CLK(CLK), .RSTn(RSTn), .Trig(Trig_a), .S_Done_Sig(a1_sd), .O_Done_Sig(a1_od),
        .S_Start_Sig(a1_s), .O_Start_Sig(a1_o), .Busy(a1_b), .Done_Sig(a1_d));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for the selected Start_Sig to be high; n = negedges waited.
    task automatic wait_start(input logic want_o, output int n);
        n = 0;
        while (!(want_o ? O_Start_Sig : S_Start_Sig) && n < 200) begin
            @(negedge CLK);
            n++;
        end
    endtask

    // Generator models for the auxiliary instances: Done 4 cycles into a letter.
    int a0_cnt = 0;
    int a1_cnt = 0;
    initial begin
        a0_sd = 0; a0_od = 0; a1_sd = 0; a1_od = 0;
        forever begin
            @(negedge CLK);
            a0_sd = 0; a0_od = 0; a1_sd = 0; a1_od = 0;
            if (a0_s | a0_o) begin
                a0_cnt++;
                if (a0_cnt == 4) begin a0_sd = a0_s; a0_od = a0_o; end
            end else a0_cnt = 0;
            if (a1_s | a1_o) begin
                a1_cnt++;
                if (a1_cnt == 4) begin a1_sd = a1_s; a1_od = a1_o; end
            end else a1_cnt = 0;
        end
    end

    // Monitor for the auxiliary pair: outputs must match, and count letters/done.
    int  aux_diff = 0, aux_s_rises = 0, aux_o_rises = 0, aux_dones = 0;
    logic p_s = 0, p_o = 0;
    initial begin
        forever begin
            @(negedge CLK);
            if ({a0_s, a0_o, a0_b, a0_d} !== {a1_s, a1_o, a1_b, a1_d}) aux_diff++;
            if (a0_s && !p_s) aux_s_rises++;
            if (a0_o && !p_o) aux_o_rises++;
            if (a0_d) aux_dones++;
            p_s = a0_s;
            p_o = a0_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic is_o;       // letter expected: 1 = O, 0 = S
        int   done_dly;   // cycles the generator model takes before Done
        int   gap_after;  // expected idle cycles afterwards (0 = end of run)
    } step_t;

    step_t steps[6];

    initial begin
        int n;
        int idle;
        logic bad;

        steps[0] = '{1'b0, 19, 20};
        steps[1] = '{1'b1,  5, 20};
        steps[2] = '{1'b0,  7, 30};
        steps[3] = '{1'b0,  3, 20};
        steps[4] = '{1'b1,  8, 20};
        steps[5] = '{1'b0,  4,  0};

        RSTn = 0; Trig = 0; S_Done_Sig = 0; O_Done_Sig = 0; Trig_a = 0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {S_Start_Sig, O_Start_Sig, Busy, Done_Sig}, 4'b0000);
        RSTn = 1;
        repeat (5) @(negedge CLK);
        check("idle_outputs", {S_Start_Sig, O_Start_Sig, Busy, Done_Sig}, 4'b0000);

        // Trigger: S_Start and Busy appear after exactly one edge.
        Trig = 1; Trig_a = 1;
        @(negedge CLK);
        check("trig_latency_s", S_Start_Sig, 1);
        check("trig_latency_busy", Busy, 1);
        Trig_a = 0;

        // Full REPEAT=2 run with Trig noise and spurious O_Done during S letters.
        for (int k = 0; k < 6; k++) begin
            check($sformatf("start_sel_%0d", k), {S_Start_Sig, O_Start_Sig},
                  steps[k].is_o ? 2'b01 : 2'b10);
            for (int i = 0; i < steps[k].done_dly; i++) begin
                Trig = (i % 2) == 1;
                O_Done_Sig = !steps[k].is_o && (i == 0);
                @(negedge CLK);
            end
            O_Done_Sig = 0;
            check($sformatf("start_hold_%0d", k), {S_Start_Sig, O_Start_Sig},
                  steps[k].is_o ? 2'b01 : 2'b10);
            Trig = 0;
            if (steps[k].is_o) O_Done_Sig = 1; else S_Done_Sig = 1;
            @(negedge CLK);
            S_Done_Sig = 0; O_Done_Sig = 0;
            check($sformatf("start_drop_%0d", k), {S_Start_Sig, O_Start_Sig}, 2'b00);
            if (steps[k].gap_after > 0) begin
                idle = 0;
                bad  = 0;
                while (!S_Start_Sig && !O_Start_Sig && idle < 200) begin
                    if (!Busy || Done_Sig) bad = 1;
                    idle++;
                    @(negedge CLK);
                end
                check($sformatf("gap_len_%0d", k), idle, steps[k].gap_after);
                check($sformatf("gap_busy_%0d", k), bad, 0);
            end else begin
                check("done_pulse", {Done_Sig, Busy}, 2'b10);
                @(negedge CLK);
                check("done_clear", {Done_Sig, Busy}, 2'b00);
                bad = 0;
                for (int i = 0; i < 40; i++) begin
                    if (Done_Sig || Busy || S_Start_Sig || O_Start_Sig) bad = 1;
                    @(negedge CLK);
                end
                check("idle_after_run", bad, 0);
            end
        end

        // REPEAT=0 plays one word and matches REPEAT=1 exactly.
        check("r0_vs_r1_diff", aux_diff, 0);
        check("r0_s_letters", aux_s_rises, 2);
        check("r0_o_letters", aux_o_rises, 1);
        check("r0_done_pulses", aux_dones, 1);

        // Trig held high across reset release is not an edge.
        RSTn = 0; Trig = 1;
        repeat (2) @(negedge CLK);
        RSTn = 1;
        repeat (5) @(negedge CLK);
        check("trig_held_idle", {S_Start_Sig, Busy}, 2'b00);
        Trig = 0;
        @(negedge CLK);
        Trig = 1;
        @(negedge CLK);
        check("trig_fresh_start", {S_Start_Sig, Busy}, 2'b11);
        Trig = 0;
        repeat (3) @(negedge CLK);
        S_Done_Sig = 1;
        @(negedge CLK);
        S_Done_Sig = 0;
        wait_start(1'b1, n);
        check("o_after_letter_gap", n, 20);

        // Reset while O is running: outputs drop without waiting for a clock.
        #1 RSTn = 0;
        #1;
        check("async_reset_o", {O_Start_Sig, Busy, S_Start_Sig}, 3'b000);
        repeat (2) @(negedge CLK);
        RSTn = 1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done_Sig || Busy || S_Start_Sig || O_Start_Sig) bad = 1;
        end
        check("post_reset_quiet", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
